// File: rtl/sdram_req_queue_if.sv
// Host-request and SDRAM-controller signal bundle for sdram_req_queue.
// The queue takes the slave modport; the host/controller side takes master.
interface sdram_req_queue_if #(
  parameter int DEPTH    = 4,
  parameter int A_WIDTH  = 23,
  parameter int BA_WIDTH = 2,
  parameter int D_WIDTH  = 16
);
  localparam int L_WIDTH = $clog2(DEPTH) + 1;

  logic                i_req_valid;
  logic                o_req_ready;
  logic                i_req_rw;
  logic [A_WIDTH-1:0]  i_req_addr;
  logic [BA_WIDTH-1:0] i_req_ba;
  logic [D_WIDTH-1:0]  i_req_data;
  logic [L_WIDTH-1:0]  o_level;
  logic                i_init_done;
  logic                i_busy;
  logic [D_WIDTH-1:0]  i_rd_data;
  logic                o_initial;
  logic                o_rw;
  logic [A_WIDTH-1:0]  o_addr;
  logic [BA_WIDTH-1:0] o_ba;
  logic [D_WIDTH-1:0]  o_wdata;
  logic                o_rsp_valid;
  logic                o_rsp_rw;
  logic [D_WIDTH-1:0]  o_rsp_data;
  logic                o_err;

  modport slave (
    input  i_req_valid, i_req_rw, i_req_addr, i_req_ba, i_req_data,
    input  i_init_done, i_busy, i_rd_data,
    output o_req_ready, o_level, o_initial, o_rw, o_addr, o_ba, o_wdata,
    output o_rsp_valid, o_rsp_rw, o_rsp_data, o_err
  );

  modport master (
    output i_req_valid, i_req_rw, i_req_addr, i_req_ba, i_req_data,
    output i_init_done, i_busy, i_rd_data,
    input  o_req_ready, o_level, o_initial, o_rw, o_addr, o_ba, o_wdata,
    input  o_rsp_valid, o_rsp_rw, o_rsp_data, o_err
  );
endinterface

// File: rtl/sdram_req_queue.sv
// Request FIFO in front of SDRAM_controller: issues one request at a time with an
// i_initial pulse, follows the o_busy rise/fall handshake and returns a response.
module sdram_req_queue #(
  parameter int DEPTH    = 4,
  parameter int A_WIDTH  = 23,
  parameter int BA_WIDTH = 2,
  parameter int D_WIDTH  = 16,
  parameter int TIMEOUT  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  sdram_req_queue_if.slave   bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic                rw;
    logic [A_WIDTH-1:0]  addr;
    logic [BA_WIDTH-1:0] ba;
    logic [D_WIDTH-1:0]  data;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  entry_t              mem_r [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [PTR_W-1:0]    level_r;
  state_t              state_r;
  state_t              state_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_s;
  logic                err_s;
  logic                capture_s;
  logic                full_s;
  logic                empty_s;
  logic                push_s;
  logic                pop_s;
  entry_t              entry_in_s;
  entry_t              head_s;
  logic                initial_r;
  logic                rw_r;
  logic [A_WIDTH-1:0]  addr_r;
  logic [BA_WIDTH-1:0] ba_r;
  logic [D_WIDTH-1:0]  wdata_r;
  logic                rsp_valid_r;
  logic                rsp_rw_r;
  logic [D_WIDTH-1:0]  rsp_data_r;
  logic                err_r;

  assign full_s  = (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]) &&
                   (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]);
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  // Ready reflects the pre-pop state, so a full queue never accepts on a pop cycle.
  assign push_s  = bus.i_req_valid && !full_s;
  assign pop_s   = (state_r == ST_IDLE) && !empty_s && bus.i_init_done && !bus.i_busy;

  assign entry_in_s = {bus.i_req_rw, bus.i_req_addr, bus.i_req_ba, bus.i_req_data};
  assign head_s     = mem_r[rd_ptr_r[IDX_W-1:0]];

  // FIFO storage, pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r[IDX_W-1:0]] <= entry_in_s;
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + PTR_W'(1);
        2'b01:   level_r <= level_r - PTR_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Issue FSM next-state; cnt_r numbers the current WAIT_BUSY cycle starting at 1
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    err_s     = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) state_s = ST_ISSUE;
        else       state_s = ST_IDLE;
      end
      ST_ISSUE: begin
        state_s = ST_WAIT_BUSY;
        cnt_s   = CNT_W'(1);
      end
      ST_WAIT_BUSY: begin
        cnt_s = cnt_r + CNT_W'(1);
        if (bus.i_busy) begin
          state_s = ST_WAIT_DONE;
        end else if (cnt_s == CNT_W'(TIMEOUT)) begin
          state_s = ST_IDLE;
          err_s   = 1'b1;
        end else begin
          state_s = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.i_busy) begin
          state_s   = ST_RESP;
          capture_s = 1'b1;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state, counter and per-state output pulses
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      initial_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      initial_r   <= (state_s == ST_ISSUE);
      rsp_valid_r <= (state_s == ST_RESP);
      err_r       <= err_s;
    end
  end

  // Command latched at pop and held until the next pop; response captured at busy fall
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rw_r       <= 1'b0;
      addr_r     <= '0;
      ba_r       <= '0;
      wdata_r    <= '0;
      rsp_rw_r   <= 1'b0;
      rsp_data_r <= '0;
    end else begin
      if (pop_s) begin
        rw_r    <= head_s.rw;
        addr_r  <= head_s.addr;
        ba_r    <= head_s.ba;
        wdata_r <= head_s.data;
      end
      if (capture_s) begin
        rsp_rw_r   <= rw_r;
        rsp_data_r <= rw_r ? '0 : bus.i_rd_data;
      end
    end
  end

  assign bus.o_req_ready = !full_s;
  assign bus.o_level     = level_r;
  assign bus.o_initial   = initial_r;
  assign bus.o_rw        = rw_r;
  assign bus.o_addr      = addr_r;
  assign bus.o_ba        = ba_r;
  assign bus.o_wdata     = wdata_r;
  assign bus.o_rsp_valid = rsp_valid_r;
  assign bus.o_rsp_rw    = rsp_rw_r;
  assign bus.o_rsp_data  = rsp_data_r;
  assign bus.o_err       = err_r;
endmodule

// File: tb/tb_sdram_req_queue.sv
// Randomised bench for sdram_req_queue: a host driver, a reactive controller model
// with a word memory, and a request-level model of queue order and handshake timing.
module tb_sdram_req_queue;
  localparam int DEPTH = 4, A_WIDTH = 23, BA_WIDTH = 2, D_WIDTH = 16, TIMEOUT = 8;

  typedef struct {
    logic        rw;
    logic [22:0] addr;
    logic [1:0]  ba;
    logic [15:0] data;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_req_queue_if #(.DEPTH(DEPTH), .A_WIDTH(A_WIDTH), .BA_WIDTH(BA_WIDTH), .D_WIDTH(D_WIDTH)) bus ();

  sdram_req_queue #(.DEPTH(DEPTH), .A_WIDTH(A_WIDTH), .BA_WIDTH(BA_WIDTH),
                    .D_WIDTH(D_WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst_n), .bus(bus));

  req_t        host_q[$];
  req_t        fifo_q[$];
  req_t        cur;
  logic [15:0] sdram_m [logic [24:0]];
  int n_checks = 0, n_errors = 0;
  int cyc = 0, idle_at = 0, err_at = -1, rsp_at = -1;
  int ctl_phase = 0, ctl_cnt = 0, force_hold = 0;
  int n_rsp = 0, n_err = 0, obs_init = 0;
  bit issue_exp = 1'b0, have_last = 1'b0, ctl_busy = 1'b0, gate_busy = 1'b0;
  bit init_done_m = 1'b0, force_timeout = 1'b0, rand_timeout = 1'b0, rand_gate = 1'b0;
  logic        rsp_rw_exp, last_rsp_rw;
  logic [15:0] rsp_data_exp, last_rsp_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic req_t mk_req(input logic rw, input int addr, input int ba, input int data);
    req_t r;
    r.rw = rw; r.addr = 23'(addr); r.ba = 2'(ba); r.data = 16'(data);
    return r;
  endfunction

  function automatic req_t rand_req();
    return mk_req(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 3),
                  $urandom_range(0, 65535));
  endfunction

  // One clock: check outputs at the falling edge, step the models, drive the next inputs.
  task automatic cycle();
    logic [24:0] key;
    @(negedge clk);
    cyc++;
    if (bus.o_initial) obs_init++;
    check_eq("err_pulse", bus.o_err, (cyc == err_at));
    check_eq("rsp_valid", bus.o_rsp_valid, (cyc == rsp_at));
    if (cyc == rsp_at) begin
      check_eq("rsp_rw", bus.o_rsp_rw, rsp_rw_exp);
      check_eq("rsp_data", bus.o_rsp_data, rsp_data_exp);
      last_rsp_rw = bus.o_rsp_rw;
      last_rsp_data = bus.o_rsp_data;
      n_rsp++;
    end
    if (cyc == err_at) begin
      n_err++;
      ctl_phase = 0;
      idle_at = cyc;
    end
    if (ctl_phase == 1) begin
      ctl_cnt--;
      if (ctl_cnt == 0) begin
        ctl_busy = 1'b1;
        bus.i_rd_data = 16'($urandom);
        ctl_phase = 2;
        ctl_cnt = (force_hold > 0) ? force_hold : $urandom_range(1, 4);
      end
    end else if (ctl_phase == 2) begin
      ctl_cnt--;
      if (ctl_cnt == 0) begin
        key = {cur.ba, cur.addr};
        ctl_busy = 1'b0;
        if (cur.rw) begin
          sdram_m[key] = cur.data;
          bus.i_rd_data = 16'($urandom);
          rsp_data_exp = 16'h0000;
        end else begin
          rsp_data_exp = sdram_m.exists(key) ? sdram_m[key] : 16'h0000;
          bus.i_rd_data = rsp_data_exp;
        end
        rsp_rw_exp = cur.rw;
        rsp_at = cyc + 1;
        idle_at = cyc + 2;
        ctl_phase = 0;
      end else begin
        bus.i_rd_data = 16'($urandom);
      end
    end
    check_eq("initial", bus.o_initial, issue_exp);
    if (issue_exp) begin
      cur = fifo_q.pop_front();
      have_last = 1'b1;
      idle_at = 1 << 30;
      if (force_timeout || (rand_timeout && $urandom_range(0, 5) == 0)) begin
        force_timeout = 1'b0;
        ctl_phase = 3;
        err_at = cyc + TIMEOUT;
      end else begin
        ctl_phase = 1;
        ctl_cnt = $urandom_range(1, TIMEOUT - 1);
      end
    end
    check_eq("level", bus.o_level, fifo_q.size());
    check_eq("ready", bus.o_req_ready, (fifo_q.size() < DEPTH));
    if (have_last) begin
      check_eq("cmd_rw", bus.o_rw, cur.rw);
      check_eq("cmd_addr", bus.o_addr, cur.addr);
      check_eq("cmd_ba", bus.o_ba, cur.ba);
      check_eq("cmd_wdata", bus.o_wdata, cur.data);
    end
    if (rand_gate) gate_busy = (cyc >= idle_at) && ($urandom_range(0, 5) == 0);
    bus.i_busy = ctl_busy | gate_busy;
    bus.i_init_done = init_done_m;
    issue_exp = (cyc >= idle_at) && (fifo_q.size() > 0) && init_done_m && !(ctl_busy | gate_busy);
    if (host_q.size() > 0) begin
      bus.i_req_valid = 1'b1;
      bus.i_req_rw = host_q[0].rw;
      bus.i_req_addr = host_q[0].addr;
      bus.i_req_ba = host_q[0].ba;
      bus.i_req_data = host_q[0].data;
      if (fifo_q.size() < DEPTH) fifo_q.push_back(host_q.pop_front());
    end else begin
      bus.i_req_valid = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((host_q.size() > 0 || fifo_q.size() > 0 || ctl_phase != 0 || cyc < idle_at) && n < budget) begin
      cycle();
      n++;
    end
    check_eq("drain_in_budget", (n < budget), 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_req_valid = 1'b0;
    #1;
    check_eq("rst_initial", bus.o_initial, 1'b0);
    check_eq("rst_rw", bus.o_rw, 1'b0);
    check_eq("rst_addr", bus.o_addr, 23'd0);
    check_eq("rst_ba", bus.o_ba, 2'd0);
    check_eq("rst_wdata", bus.o_wdata, 16'd0);
    check_eq("rst_rsp_valid", bus.o_rsp_valid, 1'b0);
    check_eq("rst_rsp_rw", bus.o_rsp_rw, 1'b0);
    check_eq("rst_rsp_data", bus.o_rsp_data, 16'd0);
    check_eq("rst_err", bus.o_err, 1'b0);
    check_eq("rst_level", bus.o_level, 3'd0);
    check_eq("rst_ready", bus.o_req_ready, 1'b1);
    @(negedge clk);
    host_q.delete();
    fifo_q.delete();
    ctl_phase = 0; ctl_busy = 1'b0; gate_busy = 1'b0;
    have_last = 1'b0; issue_exp = 1'b0;
    idle_at = 0; err_at = -1; rsp_at = -1;
    bus.i_busy = 1'b0;
    bus.i_rd_data = 16'h0000;
    rst_n = 1'b1;
  endtask

  initial begin
    int r0, e0, i0;
    bus.i_req_valid = 1'b0; bus.i_req_rw = 1'b0; bus.i_req_addr = '0; bus.i_req_ba = '0;
    bus.i_req_data = '0; bus.i_init_done = 1'b0; bus.i_busy = 1'b0; bus.i_rd_data = '0;
    do_reset();
    init_done_m = 1'b1;

    // single write, then read back the same location
    r0 = n_rsp;
    host_q.push_back(mk_req(1'b1, 5, 1, 16'habba));
    drain(200);
    check_eq("wr_rsp_cnt", n_rsp - r0, 1);
    check_eq("wr_rsp_rw", last_rsp_rw, 1'b1);
    check_eq("wr_rsp_data", last_rsp_data, 16'h0000);
    host_q.push_back(mk_req(1'b0, 5, 1, 16'h1234));
    drain(200);
    check_eq("raw_rsp_rw", last_rsp_rw, 1'b0);
    check_eq("raw_rsp_data", last_rsp_data, 16'habba);

    // fill while the controller is still initialising
    init_done_m = 1'b0;
    r0 = n_rsp;
    for (int i = 0; i < 5; i++) host_q.push_back(rand_req());
    run(10);
    check_eq("fill_level", bus.o_level, 3'd4);
    check_eq("fill_ready", bus.o_req_ready, 1'b0);
    init_done_m = 1'b1;
    drain(400);
    check_eq("fill_rsp_cnt", n_rsp - r0, 5);

    // no busy after issue: error pulse, request dropped, next one proceeds
    r0 = n_rsp; e0 = n_err;
    force_timeout = 1'b1;
    host_q.push_back(rand_req());
    host_q.push_back(rand_req());
    drain(300);
    check_eq("to_err_cnt", n_err - e0, 1);
    check_eq("to_rsp_cnt", n_rsp - r0, 1);

    // external busy holds off issue
    i0 = obs_init;
    gate_busy = 1'b1;
    host_q.push_back(rand_req());
    run(6);
    check_eq("gate_no_issue", obs_init - i0, 0);
    check_eq("gate_level", bus.o_level, 3'd1);
    gate_busy = 1'b0;
    drain(200);
    check_eq("gate_issue_cnt", obs_init - i0, 1);

    // reset while waiting for busy to fall with three entries queued
    force_hold = 20;
    for (int i = 0; i < 4; i++) host_q.push_back(rand_req());
    for (int i = 0; i < 40 && ctl_phase != 2; i++) cycle();
    run(3);
    check_eq("pre_rst_level", bus.o_level, 3'd3);
    do_reset();
    force_hold = 0;
    i0 = obs_init;
    run(8);
    check_eq("post_rst_no_issue", obs_init - i0, 0);

    // randomised traffic with timeouts, busy gating and init toggling
    rand_timeout = 1'b1;
    rand_gate = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (host_q.size() < 2 && $urandom_range(0, 2) == 0) host_q.push_back(rand_req());
      if (i % 16 == 0) init_done_m = ($urandom_range(0, 5) != 0);
      cycle();
    end
    rand_timeout = 1'b0;
    rand_gate = 1'b0;
    gate_busy = 1'b0;
    init_done_m = 1'b1;
    drain(500);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
